// File: rtl/serial_demux8_pkg.sv
// Shared types and widths for the bit-serial to byte collector.
package serial_demux8_pkg;

  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } demux_state_t;

endpackage

// File: rtl/decoder3to8.sv
// One-hot decoder with enable; turns a bit position into a shadow write strobe.
module decoder3to8
  import serial_demux8_pkg::*;
(
  input  logic              en,
  input  logic [IDX_W-1:0]  sel,
  output logic [BYTE_W-1:0] onehot
);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves onehot unassigned (no latch).
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/serial_demux8.sv
// Collects eight bit-serial beats into a byte and presents it with a one-cycle valid pulse.
module serial_demux8
  import serial_demux8_pkg::*;
#(
  parameter bit LSB_FIRST      = 1'b1,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

  demux_state_t      state;
  logic [BYTE_W-1:0] shadow;
  logic [BYTE_W-1:0] shadow_next;
  logic [BYTE_W-1:0] we;
  logic [IDX_W-1:0]  pos;
  logic              accept;

  // start outranks bit_valid, so a beat coinciding with start is never written.
  assign accept = (state == SHIFT) && !start && bit_valid;
  assign pos    = LSB_FIRST ? bit_idx : (LAST_IDX - bit_idx);

  decoder3to8 u_dec (
    .en     (accept),
    .sel    (pos),
    .onehot (we)
  );

  assign shadow_next = (shadow & ~we) | (we & {BYTE_W{bit_in}});
  assign busy        = (state == SHIFT);

  // NOTE: sequential state uses non-blocking assignments only; the shadow is a plain register, so it takes the reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      data_out   <= '0;
      bit_idx    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            bit_idx <= '0;
            if (CLEAR_ON_START) shadow <= '0;
          end
        end
        SHIFT: begin
          if (start) begin
            if (bit_idx != '0) frame_err <= 1'b1;
            bit_idx <= '0;
            if (CLEAR_ON_START) shadow <= '0;
          end else if (bit_valid) begin
            shadow <= shadow_next;
            if (bit_idx == LAST_IDX) begin
              data_out   <= shadow_next;
              data_valid <= 1'b1;
              bit_idx    <= '0;
              state      <= IDLE;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_demux8.sv
// Drives an LSB-first and an MSB-first instance with shared stimulus and compares against a frame-level model.
module tb_serial_demux8;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bit_in;
  logic       bit_valid;

  logic [7:0] dout_l, dout_m;
  logic       dv_l, dv_m;
  logic       busy_l, busy_m;
  logic [2:0] idx_l, idx_m;
  logic       ferr_l, ferr_m;

  int n_cmp = 0;
  int n_err = 0;
  string phase = "init";

  serial_demux8 #(.LSB_FIRST(1'b1), .CLEAR_ON_START(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dout_l), .data_valid(dv_l), .busy(busy_l), .bit_idx(idx_l), .frame_err(ferr_l)
  );

  serial_demux8 #(.LSB_FIRST(1'b0), .CLEAR_ON_START(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dout_m), .data_valid(dv_m), .busy(busy_m), .bit_idx(idx_m), .frame_err(ferr_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is a list of received bits; bytes are assembled arithmetically on completion.
  bit m_armed;
  int m_cnt;
  bit m_bits [8];
  int m_byte_l, m_byte_m;
  bit m_dv, m_fe;
  int n_pulses;

  task automatic model_reset();
    m_armed  = 1'b0;
    m_cnt    = 0;
    m_byte_l = 0;
    m_byte_m = 0;
    m_dv     = 1'b0;
    m_fe     = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit b, input bit v);
    m_dv = 1'b0;
    m_fe = 1'b0;
    if (!m_armed) begin
      if (s) begin
        m_armed = 1'b1;
        m_cnt   = 0;
      end
    end else if (s) begin
      m_fe  = (m_cnt != 0);
      m_cnt = 0;
    end else if (v) begin
      m_bits[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 8) begin
        m_byte_l = 0;
        m_byte_m = 0;
        for (int i = 0; i < 8; i++) begin
          if (m_bits[i]) begin
            m_byte_l += 2 ** i;
            m_byte_m += 2 ** (7 - i);
          end
        end
        m_dv    = 1'b1;
        m_armed = 1'b0;
        m_cnt   = 0;
        n_pulses++;
      end
    end
  endtask

  task automatic check(input string tag, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s/%s at %0t: got %0h expected %0h", phase, tag, $time, actual, expected);
    end
  endtask

  task automatic check_all();
    check("dout_l", int'(dout_l), m_byte_l);
    check("dout_m", int'(dout_m), m_byte_m);
    check("dv_l",   int'(dv_l),   int'(m_dv));
    check("dv_m",   int'(dv_m),   int'(m_dv));
    check("busy_l", int'(busy_l), int'(m_armed));
    check("busy_m", int'(busy_m), int'(m_armed));
    check("idx_l",  int'(idx_l),  m_cnt);
    check("idx_m",  int'(idx_m),  m_cnt);
    check("ferr_l", int'(ferr_l), int'(m_fe));
    check("ferr_m", int'(ferr_m), int'(m_fe));
  endtask

  task automatic step(input bit s, input bit b, input bit v);
    start     = s;
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
    model_step(s, b, v);
    check_all();
  endtask

  task automatic send_frame(input logic [7:0] bits_in_order);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, bits_in_order[7 - i], 1'b1);
  endtask

  initial begin
    int pulses_before;
    model_reset();
    n_pulses  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    #3;
    phase = "reset";
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    phase = "idle";
    for (int i = 0; i < 10; i++) step(1'b0, i[0], 1'b1);
    check("idle_pulses", n_pulses, 0);

    // Sequences are written in arrival order, first beat as the leftmost bit.
    phase = "a5";
    pulses_before = n_pulses;
    send_frame(8'b1010_0101);
    check("a5_byte", int'(dout_l), 'hA5);
    step(1'b0, 1'b0, 1'b0);
    check("a5_pulses", n_pulses - pulses_before, 1);

    phase = "gap";
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("gap_idx", int'(idx_l), 4);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("gap_byte", int'(dout_l), 'h3C);

    phase = "abort";
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("abort_ferr_seen", int'(ferr_l), 0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
    check("abort_byte", int'(dout_l), 'h00);

    phase = "msb";
    send_frame(8'b1100_0001);
    check("msb_byte", int'(dout_m), 'hC1);

    phase = "async_rst";
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    send_frame(8'hFF);
    check("ff_byte", int'(dout_l), 'hFF);

    phase = "random";
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_demux8.md
Name: serial_demux8

Overview:
- Receive-side counterpart of the 8:1 bit-select path.
- A source walks a 3-bit select through 0..7 and emits one bit per beat. This block collects those 8 bit-serial beats back into a parallel byte.
- Each incoming bit is steered into the byte position given by an internal index counter. A full byte is presented with a one-cycle valid pulse.
- Sits between any bit-serial link inside the CPU datapath (debug or shift path) and the byte-wide consumer.

Parameters:
- LSB_FIRST, 1: 1 = first received bit lands in data_out[0]; 0 = first bit lands in data_out[7].
- CLEAR_ON_START, 1: 1 = the shadow byte is zeroed on start; 0 = shadow bits are kept until overwritten.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame start; arms the block, index goes to 0.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is a valid beat this cycle.
- data_out  out  8  last completed byte; holds until the next completion.
- data_valid  out  1  one-cycle pulse, asserted the cycle after the 8th bit is accepted.
- busy  out  1  high while a frame is in progress (state SHIFT).
- bit_idx  out  3  current write index (the select value of the next bit).
- frame_err  out  1  one-cycle pulse when a partial frame is aborted by start.

Behaviour:
- Reset: asserting rst forces, immediately and asynchronously:
  - state = IDLE
  - shadow = 0, data_out = 8'h00, bit_idx = 0
  - data_valid = 0, busy = 0, frame_err = 0
- Reset mid-frame: the partial byte is discarded and no pulse is generated.
- States are IDLE and SHIFT.
- IDLE:
  - bit_valid is ignored.
  - start=1 -> SHIFT, bit_idx <= 0, shadow cleared if CLEAR_ON_START=1.
- SHIFT:
  - start=1 takes priority over bit_valid. The bit in that cycle is discarded and bit_idx <= 0.
  - If bit_idx != 0 when start arrives, frame_err pulses the next cycle. State stays SHIFT.
  - Otherwise bit_valid=1 writes shadow[pos] <= bit_in, with pos = bit_idx when LSB_FIRST=1 and 7-bit_idx when LSB_FIRST=0. Then bit_idx <= bit_idx+1.
  - bit_valid=0: everything holds, with no timeout.
  - Completion (bit_valid=1, start=0, bit_idx==7):
    - the 8th bit is written;
    - data_out <= full shadow including the 8th bit, registered;
    - data_valid = 1 for exactly the next cycle;
    - bit_idx wraps to 0 and state -> IDLE.
- Write enables are one-hot, decoded from pos; exactly one shadow bit is written per accepted beat.
- Latency: data_out and data_valid are updated 1 cycle after the accepting edge of the 8th bit.
- Minimum frame period is 9 cycles (start plus 8 beats). start in the completion cycle is not possible: start has priority, so that frame aborts.
- data_out changes only on completion; an abort never touches data_out.
- busy = (state==SHIFT). bit_idx reads 0 in IDLE.

Decomposition:
- Package serial_demux8_pkg:
  - typedef enum logic {IDLE, SHIFT} demux_state_t;
  - constants BYTE_W=8 and IDX_W=3.
- Sub-module decoder3to8: combinational 3-bit -> 8-bit one-hot with enable; produces the shadow write enables (the inverse of the 8:1 select).
- Index counter and FSM stay in the top module.

Test Plan:
- Reset then idle: rst pulse, then 10 cycles with bit_valid=1 and no start -> data_out=8'h00, data_valid never 1, busy=0, bit_idx=0.
- LSB-first byte: start, then bits 1,0,1,0,0,1,0,1 on 8 consecutive beats -> data_valid pulses once, the cycle after beat 8, with data_out=8'hA5; busy drops that same cycle.
- Gapped beats: same byte 8'h3C with bit_valid deasserted for 3 cycles between beats 4 and 5 -> bit_idx holds at 4 during the gap; data_out=8'h3C; a single data_valid pulse.
- Abort: start, 5 beats of 1s, start again, then 8 beats of 0s -> frame_err pulses once after the second start; data_out=8'h00 with one data_valid; the previous data_out is unchanged until then.
- MSB-first (LSB_FIRST=0): start, bits 1,1,0,0,0,0,0,1 -> data_out=8'hC1.
- Asynchronous reset mid-frame: assert rst after beat 3, between clock edges -> busy, bit_idx and frame_err go to 0 immediately, without a clock edge; no data_valid pulse; a subsequent full frame of 8'hFF completes correctly.
